// File: rtl/v7_peak_detector.sv
// v7_peak_detector
//   Sits behind the v7 trapezoidal shaping filter. A pulse starts when a
//   sample reaches THRESHOLD. While the pulse lasts, the block tracks the
//   flat-top maximum, the timestamp of that maximum and the number of samples
//   above threshold. When the pulse ends, these values go into a one-entry
//   valid/ready report register. A hold-off period then blocks re-arming on
//   ringing and undershoot.
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-low reset
//   filter_data  in   signed shaped sample, one per clock
//   out_ready    in   consumer takes the report when high with out_valid
//   out_valid    out  report register holds an unconsumed event
//   peak_value   out  signed maximum sample of the reported pulse
//   peak_time    out  timestamp of the first sample equal to the maximum
//   pulse_width  out  samples at/above THRESHOLD, saturating
//   drop_cnt     out  events lost to a full report register, saturating
//   busy         out  high while ARMED or in HOLD
module v7_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int THRESHOLD = 100,
  parameter int HOLDOFF   = 8,
  parameter int TS_W      = 16,
  parameter int WID_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] peak_value,
  output logic        [TS_W-1:0]   peak_time,
  output logic        [WID_W-1:0]  pulse_width,
  output logic        [7:0]        drop_cnt,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);
  localparam logic        [7:0]        HOLD_INIT = 8'(HOLDOFF);
  localparam logic        [WID_W-1:0]  WID_MAX   = {WID_W{1'b1}};

  state_t                     state, state_next;
  logic        [TS_W-1:0]     ts;
  logic signed [DATA_W-1:0]   max_val, max_val_next;
  logic        [TS_W-1:0]     max_ts, max_ts_next;
  logic        [WID_W-1:0]    width, width_next;
  logic        [7:0]          hold_cnt, hold_cnt_next;

  logic                       out_valid_next;
  logic signed [DATA_W-1:0]   peak_value_next;
  logic        [TS_W-1:0]     peak_time_next;
  logic        [WID_W-1:0]    pulse_width_next;
  logic        [7:0]          drop_cnt_next;

  logic                       above;
  logic                       emit;

  // Signed threshold test on the incoming sample
  assign above = (filter_data >= THR);

  // Next-state and pulse-tracking logic
  always_comb begin
    state_next    = state;
    max_val_next  = max_val;
    max_ts_next   = max_ts;
    width_next    = width;
    hold_cnt_next = hold_cnt;
    emit          = 1'b0;
    case (state)
      IDLE: begin
        if (above) begin
          state_next   = ARMED;
          max_val_next = filter_data;
          max_ts_next  = ts;
          width_next   = WID_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      ARMED: begin
        if (above) begin
          if (width != WID_MAX) begin
            width_next = width + WID_W'(1);
          end else begin
            width_next = width;
          end
          // Strictly greater: an equal plateau keeps the earliest timestamp
          if (filter_data > max_val) begin
            max_val_next = filter_data;
            max_ts_next  = ts;
          end else begin
            max_val_next = max_val;
          end
        end else begin
          emit = 1'b1;
          if (HOLDOFF == 0) begin
            state_next = IDLE;
          end else begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        // Samples are ignored here; leave after exactly HOLDOFF cycles
        hold_cnt_next = hold_cnt - 8'd1;
        if (hold_cnt <= 8'd1) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = 8'd0;
      end
    endcase
  end

  // Report register: load on emit when free or being drained, else count a drop
  always_comb begin
    out_valid_next   = out_valid;
    peak_value_next  = peak_value;
    peak_time_next   = peak_time;
    pulse_width_next = pulse_width;
    drop_cnt_next    = drop_cnt;
    if (emit && (!out_valid || out_ready)) begin
      out_valid_next   = 1'b1;
      peak_value_next  = max_val;
      peak_time_next   = max_ts;
      pulse_width_next = width;
    end else if (emit) begin
      if (drop_cnt != 8'hFF) begin
        drop_cnt_next = drop_cnt + 8'd1;
      end else begin
        drop_cnt_next = drop_cnt;
      end
    end else if (out_valid && out_ready) begin
      out_valid_next = 1'b0;
    end else begin
      out_valid_next = out_valid;
    end
  end

  // State, timestamp, tracking and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ts          <= '0;
      max_val     <= '0;
      max_ts      <= '0;
      width       <= '0;
      hold_cnt    <= 8'd0;
      out_valid   <= 1'b0;
      peak_value  <= '0;
      peak_time   <= '0;
      pulse_width <= '0;
      drop_cnt    <= 8'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      ts          <= ts + TS_W'(1);
      max_val     <= max_val_next;
      max_ts      <= max_ts_next;
      width       <= width_next;
      hold_cnt    <= hold_cnt_next;
      out_valid   <= out_valid_next;
      peak_value  <= peak_value_next;
      peak_time   <= peak_time_next;
      pulse_width <= pulse_width_next;
      drop_cnt    <= drop_cnt_next;
      busy        <= (state_next != IDLE);
    end
  end

endmodule
